// File: rtl/snake_pkg.sv
// Shared types and constants for the snake sprite pipeline.
// Used by the head renderer and the reusable address rotator.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_BLINK = 2'd1,
        ST_DEAD  = 2'd2
    } head_state_t;

    localparam int          SPRITE_SZ     = 16;
    localparam logic [23:0] KEY_COLOR_DEF = 24'h181b1d;

endpackage

// File: rtl/sprite_addr_rotate.sv
// Maps an in-cell (row, col) offset and a facing direction to a
// 16x16 sprite ROM address; shared by head, body and tail sprites.
module sprite_addr_rotate
    import snake_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  dir_t       dir,
    output logic [7:0] addr
);

    always_comb begin
        addr = {row, col};
        unique case (dir)
            DIR_UP:    addr = {row, col};
            DIR_DOWN:  addr = {~row, ~col};
            DIR_LEFT:  addr = {col, ~row};
            DIR_RIGHT: addr = {~col, row};
            default:   addr = {row, col};
        endcase
    end

endmodule

// File: rtl/head_sprite_renderer.sv
// Two-stage per-pixel head sprite fetch with frame-latched position,
// direction and death-blink visibility.
module head_sprite_renderer
    import snake_pkg::*;
#(
    parameter int          X_W           = 10,
    parameter int          Y_W           = 10,
    parameter int          GX_W          = 6,
    parameter int          GY_W          = 5,
    parameter logic [23:0] KEY_COLOR     = KEY_COLOR_DEF,
    parameter int          BLINK_FRAMES  = 8,
    parameter int          BLINK_TOGGLES = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_frame_start,
    input  logic            i_pix_valid,
    input  logic [X_W-1:0]  i_pix_x,
    input  logic [Y_W-1:0]  i_pix_y,
    input  logic [GX_W-1:0] i_head_col,
    input  logic [GY_W-1:0] i_head_row,
    input  logic [1:0]      i_dir,
    input  logic            i_dead,
    input  logic            i_restart,
    output logic [7:0]      o_rom_addr,
    input  logic [23:0]     i_rom_data,
    output logic            o_pix_valid,
    output logic            o_hit,
    output logic [23:0]     o_rgb,
    output logic            o_opaque,
    output logic [1:0]      o_state,
    output logic            o_blink_done
);

    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(BLINK_TOGGLES - 1);

    logic [GX_W-1:0] lat_col;
    logic [GY_W-1:0] lat_row;
    dir_t            lat_dir;

    head_state_t     state;
    logic [FW-1:0]   fcnt;
    logic [TW-1:0]   tcnt;
    logic            visible;

    logic            s1_valid;
    logic            s1_hit;

    logic            in_cell;
    logic [3:0]      off_r;
    logic [3:0]      off_c;
    logic [7:0]      rot_addr;

    // Cell offset is the low nibble once the high bits match the cell.
    assign in_cell = (32'(i_pix_x[X_W-1:4]) == 32'(lat_col))
                  && (32'(i_pix_y[Y_W-1:4]) == 32'(lat_row));
    assign off_r   = i_pix_y[3:0];
    assign off_c   = i_pix_x[3:0];

    sprite_addr_rotate u_rot (
        .row  (off_r),
        .col  (off_c),
        .dir  (lat_dir),
        .addr (rot_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_col     <= '0;
            lat_row     <= '0;
            lat_dir     <= DIR_UP;
            o_rom_addr  <= '0;
            s1_valid    <= 1'b0;
            s1_hit      <= 1'b0;
            o_pix_valid <= 1'b0;
            o_hit       <= 1'b0;
            o_rgb       <= '0;
            o_opaque    <= 1'b0;
        end else begin
            if (i_frame_start) begin
                lat_col <= i_head_col;
                lat_row <= i_head_row;
                lat_dir <= dir_t'(i_dir);
            end
            if (i_pix_valid && in_cell) begin
                o_rom_addr <= rot_addr;
            end
            s1_valid    <= i_pix_valid;
            s1_hit      <= i_pix_valid && in_cell && visible;
            o_pix_valid <= s1_valid;
            o_hit       <= s1_hit;
            o_rgb       <= s1_hit ? i_rom_data : '0;
            o_opaque    <= s1_hit && (i_rom_data != KEY_COLOR);
        end
    end

    // Visibility only moves on frame boundaries, so a frame never tears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_ALIVE;
            fcnt         <= '0;
            tcnt         <= '0;
            visible      <= 1'b1;
            o_blink_done <= 1'b0;
        end else begin
            o_blink_done <= 1'b0;
            if (i_restart) begin
                state   <= ST_ALIVE;
                fcnt    <= '0;
                tcnt    <= '0;
                visible <= 1'b1;
            end else if (i_frame_start) begin
                unique case (state)
                    ST_ALIVE: begin
                        if (i_dead) begin
                            state   <= ST_BLINK;
                            fcnt    <= '0;
                            tcnt    <= '0;
                            visible <= 1'b0;
                        end
                    end
                    ST_BLINK: begin
                        if (fcnt == F_LAST) begin
                            fcnt <= '0;
                            tcnt <= tcnt + 1'b1;
                            if (tcnt == T_LAST) begin
                                state        <= ST_DEAD;
                                visible      <= 1'b1;
                                o_blink_done <= 1'b1;
                            end else begin
                                visible <= ~visible;
                            end
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                    ST_DEAD: begin
                        visible <= 1'b1;
                    end
                    default: begin
                        state   <= ST_ALIVE;
                        visible <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_head_sprite_renderer.sv
// Directed bench for head_sprite_renderer: addressing, rotation,
// frame latching, death blink and mid-stream reset.
module tb_head_sprite_renderer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_frame_start;
    logic        i_pix_valid;
    logic [9:0]  i_pix_x;
    logic [9:0]  i_pix_y;
    logic [5:0]  i_head_col;
    logic [4:0]  i_head_row;
    logic [1:0]  i_dir;
    logic        i_dead;
    logic        i_restart;
    logic [7:0]  o_rom_addr;
    logic [23:0] i_rom_data;
    logic        o_pix_valid;
    logic        o_hit;
    logic [23:0] o_rgb;
    logic        o_opaque;
    logic [1:0]  o_state;
    logic        o_blink_done;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    // ROM: two named texels, everything else {c0, addr, ~addr}.
    always_comb begin
        if (o_rom_addr == 8'h00)      i_rom_data = 24'h181b1d;
        else if (o_rom_addr == 8'h05) i_rom_data = 24'hf9b3b5;
        else i_rom_data = {8'hc0, o_rom_addr, ~o_rom_addr};
    end

    head_sprite_renderer #(
        .BLINK_FRAMES  (2),
        .BLINK_TOGGLES (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_pix_valid   (i_pix_valid),
        .i_pix_x       (i_pix_x),
        .i_pix_y       (i_pix_y),
        .i_head_col    (i_head_col),
        .i_head_row    (i_head_row),
        .i_dir         (i_dir),
        .i_dead        (i_dead),
        .i_restart     (i_restart),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .o_pix_valid   (o_pix_valid),
        .o_hit         (o_hit),
        .o_rgb         (o_rgb),
        .o_opaque      (o_opaque),
        .o_state       (o_state),
        .o_blink_done  (o_blink_done)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic frame(input logic [5:0] col, input logic [4:0] row,
                         input logic [1:0] dir);
        i_head_col    = col;
        i_head_row    = row;
        i_dir         = dir;
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
    endtask

    // One isolated pixel: address after 1 cycle, result after 2.
    task automatic pix(input string tag, input logic [9:0] x,
                       input logic [9:0] y, input logic [7:0] addr,
                       input logic hit, input logic [23:0] rgb,
                       input logic opq);
        i_pix_valid = 1'b1;
        i_pix_x     = x;
        i_pix_y     = y;
        step();
        i_pix_valid = 1'b0;
        chk({tag, ".addr"}, 32'(o_rom_addr), 32'(addr));
        chk({tag, ".pv1"}, 32'(o_pix_valid), 32'd0);
        step();
        chk({tag, ".pv"}, 32'(o_pix_valid), 32'd1);
        chk({tag, ".hit"}, 32'(o_hit), 32'(hit));
        chk({tag, ".rgb"}, 32'(o_rgb), 32'(rgb));
        chk({tag, ".opq"}, 32'(o_opaque), 32'(opq));
    endtask

    initial begin
        i_rst = 1'b1;
        i_frame_start = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_x = '0;
        i_pix_y = '0;
        i_head_col = '0;
        i_head_row = '0;
        i_dir = 2'd0;
        i_dead = 1'b0;
        i_restart = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        chk("rst.state", 32'(o_state), 32'd0);
        chk("rst.pv", 32'(o_pix_valid), 32'd0);
        chk("rst.addr", 32'(o_rom_addr), 32'd0);
        chk("rst.rgb", 32'(o_rgb), 32'd0);
        chk("rst.done", 32'(o_blink_done), 32'd0);

        frame(6'd2, 5'd3, 2'd0);
        pix("up0", 10'd32, 10'd48, 8'h00, 1'b1, 24'h181b1d, 1'b0);
        pix("up5", 10'd37, 10'd48, 8'h05, 1'b1, 24'hf9b3b5, 1'b1);
        pix("miss", 10'd48, 10'd48, 8'h05, 1'b0, 24'h0, 1'b0);
        pix("missy", 10'd37, 10'd64, 8'h05, 1'b0, 24'h0, 1'b0);

        i_dir = 2'd2;
        pix("nolatch", 10'd37, 10'd48, 8'h05, 1'b1, 24'hf9b3b5, 1'b1);
        i_head_col = 6'd5;
        pix("nolatchc", 10'd32, 10'd48, 8'h00, 1'b1, 24'h181b1d, 1'b0);

        frame(6'd2, 5'd3, 2'd2);
        pix("left", 10'd37, 10'd48, 8'h5f, 1'b1, 24'hc05fa0, 1'b1);
        frame(6'd2, 5'd3, 2'd3);
        pix("right", 10'd37, 10'd48, 8'ha0, 1'b1, 24'hc0a05f, 1'b1);
        frame(6'd2, 5'd3, 2'd1);
        pix("down", 10'd37, 10'd48, 8'hfa, 1'b1, 24'hc0fa05, 1'b1);

        step();
        chk("idle.pv", 32'(o_pix_valid), 32'd0);
        chk("idle.rgb", 32'(o_rgb), 32'd0);

        // Death blink: 2 hidden frames, 2 shown, then DEAD.
        i_dead = 1'b1;
        frame(6'd2, 5'd3, 2'd0);
        chk("b1.state", 32'(o_state), 32'd1);
        pix("b1", 10'd32, 10'd48, 8'h00, 1'b0, 24'h0, 1'b0);
        frame(6'd2, 5'd3, 2'd0);
        chk("b2.state", 32'(o_state), 32'd1);
        pix("b2", 10'd32, 10'd48, 8'h00, 1'b0, 24'h0, 1'b0);
        frame(6'd2, 5'd3, 2'd0);
        pix("b3", 10'd32, 10'd48, 8'h00, 1'b1, 24'h181b1d, 1'b0);
        frame(6'd2, 5'd3, 2'd0);
        chk("b4.done", 32'(o_blink_done), 32'd0);
        pix("b4", 10'd32, 10'd48, 8'h00, 1'b1, 24'h181b1d, 1'b0);
        frame(6'd2, 5'd3, 2'd0);
        chk("dead.done", 32'(o_blink_done), 32'd1);
        chk("dead.state", 32'(o_state), 32'd2);
        step();
        chk("dead.done0", 32'(o_blink_done), 32'd0);
        pix("dead", 10'd37, 10'd48, 8'h05, 1'b1, 24'hf9b3b5, 1'b1);
        frame(6'd2, 5'd3, 2'd0);
        chk("dead.stay", 32'(o_state), 32'd2);

        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        chk("restart", 32'(o_state), 32'd0);

        // Restart wins over a same-cycle frame_start with dead high.
        i_restart = 1'b1;
        frame(6'd2, 5'd3, 2'd0);
        i_restart = 1'b0;
        chk("rs.win", 32'(o_state), 32'd0);
        pix("rs.pix", 10'd32, 10'd48, 8'h00, 1'b1, 24'h181b1d, 1'b0);
        i_dead = 1'b0;

        // Mid-stream reset flushes the pipeline.
        i_pix_valid = 1'b1;
        i_pix_x = 10'd32;
        i_pix_y = 10'd48;
        step();
        i_pix_x = 10'd37;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_pix_valid = 1'b0;
        chk("mrst.pv", 32'(o_pix_valid), 32'd0);
        chk("mrst.hit", 32'(o_hit), 32'd0);
        chk("mrst.rgb", 32'(o_rgb), 32'd0);
        chk("mrst.addr", 32'(o_rom_addr), 32'd0);
        step();
        chk("mrst.pv2", 32'(o_pix_valid), 32'd0);
        pix("dflt", 10'd5, 10'd3, 8'h35, 1'b1, 24'hc035ca, 1'b1);
        frame(6'd2, 5'd3, 2'd1);
        pix("fresh", 10'd37, 10'd48, 8'hfa, 1'b1, 24'hc0fa05, 1'b1);
        pix("oldcell", 10'd5, 10'd3, 8'hfa, 1'b0, 24'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
